fetch_unit: RTL and testbench

RV32I instruction fetch stage. Holds the program counter, issues word requests to instruction memory, buffers returned instructions in a small in-order queue, and presents them with their PC to the decoder under a valid/ready handshake. Sits directly upstream of the decoder; takes PC redirects from branch/jump resolution further down the pipe.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit_inst_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FAULT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and decoder handshake.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               inst_ready
    );

endinterface

// File: rtl/fetch_unit_inst_fifo.sv
// In-order queue of {pc, inst} entries with registered storage; flush wins over push.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     wdata_i,
    output fetch_entry_t     rdata_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = count_q != '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC generation, credit-limited imem requests, redirect/flush and an
// in-order instruction queue feeding the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              IBUF_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    localparam int             CNT_W  = $clog2(IBUF_DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT = (CNT_W + 1)'(IBUF_DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   inflight;
    logic             redirect, misaligned, req_fire, rsp_in, rsp_keep;
    logic             fifo_pop, fifo_valid;
    fetch_entry_t     fifo_head, fifo_wdata;

    assign redirect   = bus.redirect_valid;
    assign misaligned = bus.redirect_pc[1:0] != 2'b00;
    assign rsp_in     = bus.imem_rsp_valid && (pend_q != '0);
    assign inflight   = {1'b0, pend_q} + {1'b0, fifo_count};

    assign bus.imem_req_valid = (state_q == RUN) && !redirect && (inflight < CREDIT);
    assign bus.imem_req_addr  = pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // Responses are in order and requests are sequential between redirects, so the PC of
    // the next kept response is simply tracked as a running address.
    assign rsp_keep   = bus.imem_rsp_valid && (drop_q == '0) && !redirect;
    assign fifo_wdata = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};
    assign fifo_pop   = fifo_valid && bus.inst_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = (redirect && misaligned) ? FAULT : RUN;
            RUN:     if (redirect && misaligned) state_d = FAULT;
            FAULT:   if (redirect && !misaligned) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        if (req_fire) pend_d = pend_d + ONE;
        if (rsp_in)   pend_d = pend_d - ONE;

        // On redirect every still-outstanding response becomes stale
        drop_d = drop_q;
        if (redirect)
            drop_d = rsp_in ? pend_q - ONE : pend_q;
        else if (bus.imem_rsp_valid && (drop_q != '0))
            drop_d = drop_q - ONE;

        pc_d = pc_q;
        if (redirect)      pc_d = bus.redirect_pc;
        else if (req_fire) pc_d = pc_q + 32'd4;

        rsp_pc_d = rsp_pc_q;
        if (redirect)      rsp_pc_d = bus.redirect_pc;
        else if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            pend_q   <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
        end
    end

    inst_fifo #(
        .DEPTH (IBUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_keep),
        .pop_i   (fifo_pop),
        .flush_i (redirect),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign bus.inst_valid  = fifo_valid;
    assign bus.inst        = fifo_valid ? fifo_head.inst : INST_NOP;
    assign bus.inst_pc     = fifo_valid ? fifo_head.pc : '0;
    assign bus.fetch_fault = state_q == FAULT;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus redirect, fault and wrap sequences.
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .IBUF_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .IBUF_DEPTH(2)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] mq[$];
    logic [31:0] alog[$];
    logic [31:0] dpc[$];
    logic [31:0] ddat[$];
    logic        mem_hold;

    // Second instance: latency-1 memory that always answers, decoder always ready
    always @(posedge clk) begin
        if (rst) begin
            bus2.imem_rsp_valid <= 1'b0;
            bus2.imem_rsp_data  <= 32'h0;
        end else begin
            bus2.imem_rsp_valid <= bus2.imem_req_valid && bus2.imem_req_ready;
            bus2.imem_rsp_data  <= ~bus2.imem_req_addr;
        end
    end

    logic [31:0] wpc [4];
    logic [31:0] wdat [4];
    int          wn;
    always @(negedge clk) begin
        if (rst) wn = 0;
        else if (bus2.inst_valid && wn < 4) begin
            wpc[wn]  = bus2.inst_pc;
            wdat[wn] = bus2.inst;
            wn++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: log accepted request / decoder pop, cross the edge, present the memory response
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        if (bus.inst_valid && bus.inst_ready) begin
            dpc.push_back(bus.inst_pc);
            ddat.push_back(bus.inst);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            mq.push_back(a);
            alog.push_back(a);
        end
        if (!mem_hold && mq.size() > 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = ~mq.pop_front();
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        mem_hold           = 1'b0;
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        alog.delete();
        dpc.delete();
        ddat.delete();
    endtask

    task automatic chk_reset(input string tag);
        #1;
        chk({tag, " rst req_valid"}, bus.imem_req_valid, 0);
        chk({tag, " rst req_addr"}, bus.imem_req_addr, 32'h0);
        chk({tag, " rst inst_valid"}, bus.inst_valid, 0);
        chk({tag, " rst inst"}, bus.inst, 32'h0000_0013);
        chk({tag, " rst inst_pc"}, bus.inst_pc, 32'h0);
        chk({tag, " rst fetch_fault"}, bus.fetch_fault, 0);
    endtask

    initial begin
        int stale;
        checks   = 0;
        failures = 0;
        //                  rdy   rv    ra            iv    ipc
        tbl[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        tbl[5] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
        tbl[7] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

        bus.imem_req_ready  = 1'b1;
        bus2.imem_req_ready = 1'b1;
        bus2.inst_ready     = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'h0;

        // Streaming from reset, latency-1 memory
        do_reset();
        chk_reset("s1");
        for (int i = 0; i < 8; i++) begin
            bus.inst_ready = tbl[i].rdy;
            #1;
            chk($sformatf("c%0d req_valid", i), bus.imem_req_valid, tbl[i].rv);
            chk($sformatf("c%0d req_addr", i), bus.imem_req_addr, tbl[i].ra);
            chk($sformatf("c%0d inst_valid", i), bus.inst_valid, tbl[i].iv);
            chk($sformatf("c%0d inst_pc", i), bus.inst_pc, tbl[i].ipc);
            chk($sformatf("c%0d inst", i), bus.inst, tbl[i].iv ? ~tbl[i].ipc : 32'h0000_0013);
            tick();
        end

        // Decoder stalled: credit caps fetches at the queue depth
        do_reset();
        chk_reset("s2");
        repeat (12) tick();
        chk("stall accepts", alog.size(), 2);
        chk("stall acc0", alog[0], 32'h0);
        chk("stall acc1", alog[1], 32'h4);
        #1;
        chk("stall head valid", bus.inst_valid, 1);
        chk("stall head pc", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        repeat (10) tick();
        chk("release ndeliv>=3", dpc.size() >= 3, 1);
        chk("release pc0", dpc[0], 32'h0);
        chk("release pc1", dpc[1], 32'h4);
        chk("release pc2", dpc[2], 32'h8);
        chk("release inst1", ddat[1], ~32'h4);
        chk("resume addr", alog[2], 32'h8);

        // Redirect with two responses outstanding
        do_reset();
        chk_reset("s3");
        mem_hold       = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        chk("s3 pending", alog.size(), 2);
        chk("s3 redir req_valid", bus.imem_req_valid, 0);
        tick();
        bus.redirect_valid = 1'b0;
        mem_hold           = 1'b0;
        #1;
        chk("s3 n+1 inst_valid", bus.inst_valid, 0);
        chk("s3 n+1 req_addr", bus.imem_req_addr, 32'h100);
        dpc.delete();
        ddat.delete();
        repeat (10) tick();
        chk("s3 first pc", dpc[0], 32'h100);
        chk("s3 first inst", ddat[0], ~32'h100);
        stale = 0;
        foreach (dpc[k]) if (dpc[k] < 32'h100) stale++;
        chk("s3 stale delivered", stale, 0);

        // Redirect coinciding with a response and a dequeue
        do_reset();
        bus.inst_ready = 1'b1;
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        #1;
        chk("s4 rsp present", bus.imem_rsp_valid, 1);
        chk("s4 head valid", bus.inst_valid, 1);
        chk("s4 head pc", bus.inst_pc, 32'h0);
        tick();
        chk("s4 pop honored", dpc.size() == 1 && dpc[0] == 32'h0, 1);
        dpc.delete();
        ddat.delete();
        bus.redirect_valid = 1'b0;
        #1;
        chk("s4 n+1 inst_valid", bus.inst_valid, 0);
        chk("s4 n+1 req_valid", bus.imem_req_valid, 1);
        chk("s4 n+1 req_addr", bus.imem_req_addr, 32'h300);
        repeat (8) tick();
        chk("s4 first pc", dpc[0], 32'h300);
        chk("s4 first inst", ddat[0], ~32'h300);
        chk("s4 second pc", dpc[1], 32'h304);

        // Misaligned redirect halts fetch until an aligned redirect
        do_reset();
        bus.inst_ready = 1'b1;
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        #1;
        chk("s5 redir masks req", bus.imem_req_valid, 0);
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("s5 f%0d fault", i), bus.fetch_fault, 1);
            chk($sformatf("s5 f%0d req_valid", i), bus.imem_req_valid, 0);
            chk($sformatf("s5 f%0d inst_valid", i), bus.inst_valid, 0);
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.redirect_valid = 1'b0;
        dpc.delete();
        ddat.delete();
        #1;
        chk("s5 recover fault", bus.fetch_fault, 0);
        chk("s5 recover req_valid", bus.imem_req_valid, 1);
        chk("s5 recover req_addr", bus.imem_req_addr, 32'h200);
        repeat (8) tick();
        chk("s5 first pc", dpc[0], 32'h200);
        chk("s5 first inst", ddat[0], ~32'h200);

        // PC wrap on the second instance (ran alongside since the last reset)
        chk("wrap ndeliv>=2", wn >= 2, 1);
        chk("wrap pc0", wpc[0], 32'hFFFF_FFFC);
        chk("wrap pc1", wpc[1], 32'h0000_0000);
        chk("wrap inst0", wdat[0], 32'h0000_0003);
        chk("wrap inst1", wdat[1], 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
